// File: rtl/serial_to_parallel.sv
// MSB-first serial receiver: gathers data_size bits into a word.
// Completed words are presented on a registered valid/ready output.
module serial_to_parallel #(
  parameter int data_size = 64,
  parameter int CNT_W = $clog2(data_size)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 DATA,
  input  logic                 SHIFT_EN,
  input  logic                 CLEAR,
  output logic [data_size-1:0] DATA_OUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [CNT_W-1:0]     BIT_COUNT,
  output logic                 OVERRUN
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(data_size - 1);

  logic [data_size-1:0] sr_tmp;
  logic [data_size-1:0] word;
  logic                 shift;
  logic                 complete;
  logic                 consume;
  logic                 deliver;

  always_comb begin
    word     = {sr_tmp[data_size-2:0], DATA};
    shift    = SHIFT_EN & ~CLEAR;
    complete = shift & (BIT_COUNT == LAST);
    consume  = OUT_VALID & OUT_READY;
    deliver  = complete & (~OUT_VALID | OUT_READY);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_tmp    <= '0;
      BIT_COUNT <= '0;
      OVERRUN   <= 1'b0;
    end else if (CLEAR) begin
      sr_tmp    <= '0;
      BIT_COUNT <= '0;
      OVERRUN   <= 1'b0;
    end else if (shift) begin
      sr_tmp <= word;
      if (complete) begin
        BIT_COUNT <= '0;
        // word could not be handed off: drop it, remember it
        if (!deliver)
          OVERRUN <= 1'b1;
      end else begin
        BIT_COUNT <= BIT_COUNT + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA_OUT  <= '0;
      OUT_VALID <= 1'b0;
    end else if (deliver) begin
      DATA_OUT  <= word;
      OUT_VALID <= 1'b1;
    end else if (consume) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Serial-to-parallel receive shift register: the deserializing end of the team's MSB-first serial link. It samples one serial bit per enabled cycle and assembles data_size bits into a word. Each completed word is presented on a registered parallel output with a valid/ready handshake, and an overrun flag reports words that could not be delivered.

Parameters:
data_size, 64, word width in bits; legal range >= 2
CNT_W, $clog2(data_size), width of the bit counter (derived; do not override)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  asynchronous reset, active-high
DATA  input  1  serial data in, MSB of each word first
SHIFT_EN  input  1  sample DATA on this rising edge
CLEAR  input  1  synchronous frame restart; discards the partial word
DATA_OUT  output  data_size  last delivered word (registered)
OUT_VALID  output  1  DATA_OUT holds an unconsumed word
OUT_READY  input  1  consumer accepts DATA_OUT when OUT_VALID=1
BIT_COUNT  output  CNT_W  bits collected in the current partial word
OVERRUN  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (RST=1, async): SR_TMP=0, BIT_COUNT=0, DATA_OUT=0, OUT_VALID=0, OVERRUN=0. Reset mid-word loses the partial word.
- Shift, on an edge with SHIFT_EN=1 and CLEAR=0:
  - SR_TMP <= {SR_TMP[data_size-2:0], DATA}. The first bit received ends up in the MSB.
  - If BIT_COUNT < data_size-1: BIT_COUNT increments.
  - If BIT_COUNT == data_size-1: completion. BIT_COUNT wraps to 0, and the completed word is {SR_TMP[data_size-2:0], DATA}.
- Gaps: SHIFT_EN=0 holds SR_TMP and BIT_COUNT. Gaps of any length are legal.
- Completion delivery, in the same edge:
  - If OUT_VALID=0, or OUT_VALID=1 with OUT_READY=1: DATA_OUT <= word, OUT_VALID <= 1. Back-to-back delivery is allowed.
  - Otherwise the word is dropped, OVERRUN <= 1, and DATA_OUT and OUT_VALID are unchanged.
- Latency: OUT_VALID is high in the cycle after the edge that samples the last bit.
- Handshake:
  - Transfer occurs on an edge with OUT_VALID=1 and OUT_READY=1.
  - With no simultaneous completion, OUT_VALID <= 0. DATA_OUT keeps its value and is not cleared.
  - OUT_READY is ignored while OUT_VALID=0.
- CLEAR=1, synchronous:
  - SR_TMP <= 0, BIT_COUNT <= 0, OVERRUN <= 0.
  - CLEAR has priority over SHIFT_EN: the sample is discarded and no completion occurs.
  - The output handshake is unaffected: OUT_VALID/DATA_OUT behave as above, including consume on OUT_READY.
- OVERRUN stays set until CLEAR or RST. Shifting continues normally while it is set.
- No combinational path from inputs to outputs.

Test Plan (data_size=8 unless noted):
1. Basic receive: RST pulse, OUT_READY=0, then bits 1,0,1,0,0,1,0,1 on 8 consecutive SHIFT_EN edges -> cycle after the 8th edge: DATA_OUT=8'hA5, OUT_VALID=1, BIT_COUNT=0, OVERRUN=0. OUT_READY=1 for one edge -> OUT_VALID=0, DATA_OUT stays 8'hA5.
2. Gapped input plus back-to-back: same 8'h3C with SHIFT_EN low for 3 cycles between every bit, then 8'hC3 immediately, OUT_READY tied 1 -> two words delivered in order (8'h3C, then 8'hC3), OUT_VALID pulsing one cycle each; BIT_COUNT holds during gaps.
3. Overrun: OUT_READY=0; receive 8'h11 then 8'h22 -> DATA_OUT=8'h11, OUT_VALID=1, OVERRUN=1 after the 16th bit. OUT_READY=1 then receive 8'h33 -> DATA_OUT=8'h33, OVERRUN remains 1 until a CLEAR pulse sets it to 0.
4. Simultaneous completion and consume: OUT_VALID=1 with 8'h55, OUT_READY=1 on the same edge as the last bit of 8'hAA -> DATA_OUT=8'hAA, OUT_VALID stays 1, OVERRUN=0.
5. CLEAR mid-word:
   - Sequence: 5 bits, then CLEAR together with SHIFT_EN, then 8 bits of 8'h81.
   - Required: BIT_COUNT=0 after the CLEAR edge; DATA_OUT=8'h81 after the 8th post-clear bit.
   - CLEAR while OUT_VALID=1 and OUT_READY=0 leaves OUT_VALID=1.
6. Async reset mid-word and width check: RST asserted between clock edges after 3 bits -> all outputs 0 immediately, without waiting for CLK. Rerun scenario 1 with data_size=64 and word 64'h0123_4567_89AB_CDEF, MSB first -> exact match.
